// File: rtl/snake_pkg.sv
// Shared types and default screen geometry for the Snake VGA game-flow logic.
package snake_pkg;

  localparam int unsigned SCREEN_W      = 160;
  localparam int unsigned SCREEN_H      = 120;
  localparam int unsigned SCREEN_PIXELS = SCREEN_W * SCREEN_H;

  typedef enum logic [2:0] {
    TITLE,
    CLEAR,
    PLAY,
    PAUSE,
    FLASH,
    GAMEOVER
  } flow_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchroniser for an active-low push key plus a registered one-cycle
// press pulse on the synchronised falling edge.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  // sync[0..1] synchronise; sync[2] holds the previous synchronised level
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= 3'b111;
      press <= 1'b0;
    end else begin
      sync  <= {sync[1:0], key_n};
      press <= sync[2] & ~sync[1];
    end
  end

endmodule

// File: rtl/snake_flow_ctrl.sv
// Snake game-flow sequencer: title, clear, play, death flash, game over, with a
// multi-life respawn loop. Define PAUSE_EN to let the key toggle PLAY/PAUSE.
module snake_flow_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = SCREEN_PIXELS,
  parameter int unsigned FLASH_CYCLES = SCREEN_PIXELS,
  parameter int unsigned LIVES        = 3,
  localparam int unsigned MAX_CYC     = max_u(CLEAR_CYCLES, FLASH_CYCLES),
  localparam int unsigned CNT_W       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1,
  localparam int unsigned LIVES_W     = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_n,
  input  logic               is_dead,
  output logic               show_title,
  output logic               draw_black,
  output logic               draw_red,
  output logic               show_game_over,
  output logic               go,
  output logic [CNT_W-1:0]   fill_idx,
  output logic [LIVES_W-1:0] lives_left
);

  logic        press;
  logic        clear_done;
  logic        flash_done;
  logic        no_lives;
  flow_state_t state;
  flow_state_t state_nxt;

  key_edge u_key_edge (
    .clk   (clk),
    .rst   (rst),
    .key_n (start_n),
    .press (press)
  );

  function automatic flow_state_t next_state(
    input flow_state_t s,
    input logic        prs,
    input logic        dead,
    input logic        clr_done,
    input logic        fl_done,
    input logic        empty
  );
    flow_state_t n;
    n = s;
    case (s)
      TITLE:    if (prs) n = CLEAR;
      CLEAR:    if (clr_done) n = PLAY;
      // death outranks a same-cycle key press
      PLAY: begin
        if (dead) n = FLASH;
`ifdef PAUSE_EN
        else if (prs) n = PAUSE;
`endif
      end
`ifdef PAUSE_EN
      PAUSE:    if (prs) n = PLAY;
`endif
      FLASH:    if (fl_done) n = empty ? GAMEOVER : CLEAR;
      GAMEOVER: if (prs) n = TITLE;
      default:  n = TITLE;
    endcase
    return n;
  endfunction

  assign clear_done = (fill_idx == CNT_W'(CLEAR_CYCLES - 1));
  assign flash_done = (fill_idx == CNT_W'(FLASH_CYCLES - 1));
  assign no_lives   = (lives_left == '0);
  assign state_nxt  = next_state(state, press, is_dead, clear_done, flash_done, no_lives);

  // State, fill counter, lives and Moore outputs all registered off state_nxt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= TITLE;
      fill_idx       <= '0;
      lives_left     <= LIVES_W'(LIVES);
      show_title     <= 1'b1;
      draw_black     <= 1'b0;
      draw_red       <= 1'b0;
      show_game_over <= 1'b0;
      go             <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state_nxt == state) && ((state == CLEAR) || (state == FLASH)))
        fill_idx <= fill_idx + CNT_W'(1);
      else
        fill_idx <= '0;

      if ((state == TITLE) && (state_nxt == CLEAR))
        lives_left <= LIVES_W'(LIVES);
      else if ((state == PLAY) && (state_nxt == FLASH))
        lives_left <= lives_left - LIVES_W'(1);

      show_title     <= (state_nxt == TITLE);
      draw_black     <= (state_nxt == CLEAR);
      draw_red       <= (state_nxt == FLASH);
      show_game_over <= (state_nxt == GAMEOVER);
      go             <= (state_nxt == PLAY);
    end
  end

endmodule

// File: tb/tb_snake_flow_ctrl.sv
// Scoreboard bench for snake_flow_ctrl: a phase/timestamp reference model pushes
// the expected outputs every edge and a negedge monitor compares them.
module tb_snake_flow_ctrl;

  localparam int unsigned CC = 8;
  localparam int unsigned FC = 4;
  localparam int unsigned LV = 2;
  localparam int unsigned CW = 3;
  localparam int unsigned LW = 2;

`ifdef PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  localparam int PH_TITLE = 0, PH_CLEAR = 1, PH_PLAY = 2, PH_PAUSE = 3, PH_FLASH = 4, PH_OVER = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_n = 1'b1;
  logic          is_dead = 1'b0;
  logic          show_title, draw_black, draw_red, show_game_over, go;
  logic [CW-1:0] fill_idx;
  logic [LW-1:0] lives_left;

  snake_flow_ctrl #(
    .CLEAR_CYCLES (CC),
    .FLASH_CYCLES (FC),
    .LIVES        (LV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_n        (start_n),
    .is_dead        (is_dead),
    .show_title     (show_title),
    .draw_black     (draw_black),
    .draw_red       (draw_red),
    .show_game_over (show_game_over),
    .go             (go),
    .fill_idx       (fill_idx),
    .lives_left     (lives_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          t;
    logic          b;
    logic          r;
    logic          o;
    logic          g;
    logic [CW-1:0] idx;
    logic [LW-1:0] lives;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: current phase, cycle it was entered, lives, and raw key history
  int       cyc = 0;
  int       ph = PH_TITLE;
  int       entry = 0;
  int       lives_m = LV;
  logic [3:0] hist = 4'hF;
  int       seen_over = 0, seen_respawn = 0, seen_pause = 0;

  function automatic obs_t model_obs();
    obs_t e;
    e.t     = (ph == PH_TITLE);
    e.b     = (ph == PH_CLEAR);
    e.r     = (ph == PH_FLASH);
    e.o     = (ph == PH_OVER);
    e.g     = (ph == PH_PLAY);
    e.idx   = (ph == PH_CLEAR || ph == PH_FLASH) ? CW'(cyc - entry) : '0;
    e.lives = LW'(lives_m);
    return e;
  endfunction

  always @(posedge clk) begin
    logic prs;
    cyc = cyc + 1;
    if (!rst) begin
      ph = PH_TITLE; lives_m = LV; hist = 4'hF; entry = cyc;
    end else begin
      // key sampled low for the first time 3 edges ago acts now
      prs = hist[3] & ~hist[2];
      case (ph)
        PH_TITLE: if (prs) begin ph = PH_CLEAR; entry = cyc; lives_m = LV; end
        PH_CLEAR: if (cyc - entry == CC) ph = PH_PLAY;
        PH_PLAY: begin
          if (is_dead) begin ph = PH_FLASH; entry = cyc; lives_m = lives_m - 1; end
          else if (prs && PAUSE_ON) begin ph = PH_PAUSE; seen_pause++; end
        end
        PH_PAUSE: if (prs) ph = PH_PLAY;
        PH_FLASH: if (cyc - entry == FC) begin
          if (lives_m > 0) begin ph = PH_CLEAR; entry = cyc; seen_respawn++; end
          else begin ph = PH_OVER; seen_over++; end
        end
        PH_OVER: if (prs) ph = PH_TITLE;
        default: ph = PH_TITLE;
      endcase
      hist = {hist[2:0], start_n};
    end
    exp_q.push_back(model_obs());
  end

  always @(negedge clk) begin
    obs_t got, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {show_title, draw_black, draw_red, show_game_over, go, fill_idx, lives_left};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d got t%0b b%0b r%0b o%0b go%0b idx%0d lives%0d want t%0b b%0b r%0b o%0b go%0b idx%0d lives%0d",
                 cyc, got.t, got.b, got.r, got.o, got.g, got.idx, got.lives,
                 want.t, want.b, want.r, want.o, want.g, want.idx, want.lives);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press_key(input int hold);
    start_n = 1'b0;
    repeat (hold) tick();
    start_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic wait_phase(input int p, input int budget, input string name);
    int n;
    n = 0;
    while (ph != p && n < budget) begin
      tick();
      n++;
    end
    if (ph != p) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_%s timeout: phase %0d, required %0d", name, ph, p);
    end
  endtask

  task automatic pulse_dead();
    is_dead = 1'b1;
    tick();
    is_dead = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0b required %0b", name, got, want);
    end
  endtask

  initial begin
    int hold_left;
    int n;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Reset in the middle of a clear fill
    press_key(2);
    n = 0;
    while (!(ph == PH_CLEAR && cyc - entry == 5) && n < 40) begin tick(); n++; end
    check_bit("reach_fill5", fill_idx == CW'(5), 1'b1);
    rst = 1'b0;
    #1;
    check_bit("rst_title", show_title, 1'b1);
    check_bit("rst_black", draw_black, 1'b0);
    check_bit("rst_idx0", fill_idx == '0, 1'b1);
    check_bit("rst_lives", lives_left == LW'(LV), 1'b1);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Start, die once (respawn), die again (game over), back to title
    press_key(3);
    wait_phase(PH_PLAY, 40, "play1");
    pulse_dead();
    check_bit("flash_after_dead", draw_red, 1'b1);
    wait_phase(PH_PLAY, 40, "respawn");
    pulse_dead();
    wait_phase(PH_OVER, 40, "over");
    check_bit("over_sel", show_game_over, 1'b1);
    press_key(2);
    wait_phase(PH_TITLE, 10, "title");

    // Pause with a long key hold, then resume
    press_key(2);
    wait_phase(PH_PLAY, 40, "play2");
    press_key(50);
    check_bit("pause_go", go, !PAUSE_ON);
    repeat (3) tick();
    press_key(2);
    repeat (3) tick();
    check_bit("resume_go", go, 1'b1);

    // Death and press effective on the same edge
    wait_phase(PH_PLAY, 40, "play3");
    start_n = 1'b0;
    repeat (3) tick();
    is_dead = 1'b1;
    tick();
    is_dead = 1'b0;
    start_n = 1'b1;
    check_bit("race_red", draw_red, 1'b1);
    check_bit("race_go", go, 1'b0);

    // Randomised key presses and deaths
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) start_n = 1'b1;
      end else if ($urandom_range(0, 19) == 0) begin
        start_n   = 1'b0;
        hold_left = $urandom_range(1, 60);
      end
      is_dead = ($urandom_range(0, 15) == 0);
      tick();
    end
    is_dead = 1'b0;
    start_n = 1'b1;
    repeat (3) tick();

    check_bit("cov_over", seen_over > 0, 1'b1);
    check_bit("cov_respawn", seen_respawn > 0, 1'b1);
    check_bit("cov_pause", seen_pause > 0, PAUSE_ON);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snake_flow_ctrl.md
# snake_flow_ctrl

Parametrised top-level game-flow sequencer for the Snake VGA design. It takes the title-screen key and the game logic's death flag, and sequences title, screen clear, play, optional pause, death flash and game-over. It adds a multi-life respawn loop and exports the fill counter as a pixel index for the framebuffer writer. It sits between the key inputs, the snake/game-logic block and the VGA draw multiplexer.

## Interface
Parameters:
- CLEAR_CYCLES, 19200, cycles spent filling black (one per pixel, 160x120); must be ≥1
- FLASH_CYCLES, 19200, cycles spent filling red after a death; must be ≥1
- LIVES, 3, lives per game; must be ≥1; LIVES=1 means no respawn
- CNT_W (localparam), $clog2 of max(CLEAR_CYCLES, FLASH_CYCLES), minimum 1
- LIVES_W (localparam), $clog2(LIVES+1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start_n  in  1  push key, active-low, asynchronous to clk
- is_dead  in  1  level from game logic; sampled only in PLAY
- show_title  out  1  title screen select
- draw_black  out  1  black fill active; game logic also resets the snake while this is high
- draw_red  out  1  red death-flash fill active
- show_game_over  out  1  game-over screen select
- go  out  1  game logic may advance
- fill_idx  out  CNT_W  current fill pixel index; 0 outside CLEAR and FLASH
- lives_left  out  LIVES_W  remaining lives

## Operation
- start_n passes through a 2-flop synchroniser. press is a 1-cycle pulse on the falling edge of the synchronised signal, so one key hold produces exactly one press.
- States and outputs (Moore, decoded from the state register):
  - TITLE: show_title=1.
  - CLEAR: draw_black=1.
  - PLAY: go=1.
  - PAUSE: all select outputs 0.
  - FLASH: draw_red=1.
  - GAMEOVER: show_game_over=1.
- Exactly one select output is high in every state except PAUSE.
- Transitions:
  - TITLE → CLEAR on press. lives_left is loaded with LIVES on this transition.
  - CLEAR → PLAY when cnt==CLEAR_CYCLES-1.
  - PLAY → FLASH on is_dead. lives_left is decremented on this transition.
  - PLAY → PAUSE on press, only when PAUSE is enabled (see Configuration).
  - PAUSE → PLAY on press.
  - FLASH → CLEAR when cnt==FLASH_CYCLES-1 and lives_left≠0 (respawn).
  - FLASH → GAMEOVER when cnt==FLASH_CYCLES-1 and lives_left==0.
  - GAMEOVER → TITLE on press.
- Counter cnt:
  - Increments every cycle in CLEAR and FLASH.
  - Returns to 0 on the terminal transition.
  - Held at 0 in all other states, so no stale count carries into the next fill.
  - fill_idx = cnt.
- Simultaneous is_dead and press in PLAY: death wins, next state FLASH.
- press and is_dead are ignored in states not listed above. is_dead is never latched.
- Game logic must drop is_dead while draw_black is high; otherwise the game dies again on the first PLAY cycle.
- lives_left never underflows. The decrement occurs only in PLAY, and PLAY is reachable only with lives_left ≥ 1.

## Timing
- Reset values (asserted at any time, including mid-fill):
  - state=TITLE, so show_title=1 and all other selects 0.
  - fill_idx=0, lives_left=LIVES, synchroniser flops=1.
- Key latency: start_n falling → press high 2–3 clk edges later → state change on the next edge.
- CLEAR holds draw_black for exactly CLEAR_CYCLES cycles, with fill_idx running 0..CLEAR_CYCLES-1. FLASH behaves the same with FLASH_CYCLES.
- is_dead high at edge N in PLAY: go=0 and draw_red=1 from edge N onward; lives_left is updated at the same edge.

## Configuration
- PAUSE_EN defined: the PAUSE state exists and press toggles PLAY and PAUSE.
- PAUSE_EN undefined: the PAUSE state and its decode are compiled out, and press in PLAY is ignored.

## Structure
- snake_pkg holds the flow_state_t enum (TITLE, CLEAR, PLAY, PAUSE, FLASH, GAMEOVER) and the default-geometry constants (160, 120, 19200).
- One sub-module, key_edge: 2-flop synchroniser plus falling-edge pulse, async active-low reset to 1.

## Test plan
Bench parameters CLEAR_CYCLES=8, FLASH_CYCLES=4, LIVES=2, PAUSE_EN defined.
- Reset mid-fill: assert rst at fill_idx=5 → show_title=1, fill_idx=0, lives_left=2 immediately.
- Start and clear: press → draw_black high exactly 8 cycles, fill_idx 0..7, then go=1, lives_left=2.
- Respawn: is_dead pulse in PLAY → lives_left=1, draw_red for 4 cycles (fill_idx 0..3), draw_black for 8, then go=1.
- Game over: second is_dead → lives_left=0, FLASH 4 cycles, then show_game_over=1; press → show_title=1.
- Pause and key hold: press in PLAY → go=0 with no select high; holding start_n low for 50 cycles keeps PAUSE; release and press again → go=1.
- Death/press race: is_dead and press in the same PLAY cycle → FLASH, not PAUSE.
